stream_video_sink: RTL and testbench

STREAM_VIDEO_SINK -- requirements
Module: stream_video_sink

---
 rtl/stream_video_sink_pkg.sv | 11 +
 rtl/stream_frame_counter.sv | 57 +++++
 rtl/stream_video_sink.sv | 114 +++++++++++
 tb/tb_stream_video_sink.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_video_sink_pkg.sv
// Shared definitions for the video stream sink: FSM state encoding and counter widths.
package stream_video_sink_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef logic [0:0] sink_state_t;

    localparam sink_state_t SEEK_SOF = 1'b0;
    localparam sink_state_t ACTIVE   = 1'b1;

endpackage

// File: rtl/stream_frame_counter.sv
// Pixel/line position tracker for one video frame; flags line and frame ends and
// tlast placement errors for the beat currently being accepted.
module stream_frame_counter
    import stream_video_sink_pkg::*;
#(
    parameter int FRAME_WIDTH  = 20,
    parameter int FRAME_HEIGHT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic sof,
    input  logic tlast,
    output logic line_end,
    output logic frame_end,
    output logic eol_early,
    output logic eol_late
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    logic [XW-1:0] x;
    logic [XW-1:0] x_eff;
    logic [YW-1:0] y;
    logic [YW-1:0] y_eff;
    logic          last_pix;
    logic          last_line;

    // A start-of-frame beat is evaluated as pixel (0,0) before any end-of-line rule.
    always_comb begin
        x_eff     = sof ? '0 : x;
        y_eff     = sof ? '0 : y;
        last_pix  = (x_eff == XW'(FRAME_WIDTH - 1));
        last_line = (y_eff == YW'(FRAME_HEIGHT - 1));
        line_end  = step && (tlast || last_pix);
        frame_end = line_end && last_line;
        eol_early = step && tlast && !last_pix;
        eol_late  = step && last_pix && !tlast;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (line_end) begin
                x <= '0;
                y <= last_line ? '0 : y_eff + YW'(1);
            end else begin
                x <= x_eff + XW'(1);
                y <= y_eff;
            end
        end
    end

endmodule

// File: rtl/stream_video_sink.sv
// AXI4-Stream video sink: checks frame/line framing, XORs pixel data per frame and
// reports completed frames with sticky framing-error flags.
//
// state    | meaning
// SEEK_SOF | waiting for a tuser beat; other beats are dropped silently
// ACTIVE   | inside a frame, tracking x/y and accumulating the data XOR
module stream_video_sink
    import stream_video_sink_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int FRAME_WIDTH  = 20,
    parameter int FRAME_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_axis_video_tdata,
    input  logic                   s_axis_video_tvalid,
    output logic                   s_axis_video_tready,
    input  logic                   s_axis_video_tuser,
    input  logic                   s_axis_video_tlast,
    input  logic                   ready_en,
    input  logic                   err_clr,
    output logic                   frame_done,
    output logic                   frame_ok,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [DATA_WIDTH-1:0]  frame_xor,
    output logic                   err_sof_early,
    output logic                   err_eol_early,
    output logic                   err_eol_late
);

    sink_state_t           state;
    logic                  beat;
    logic                  in_active;
    logic                  step;
    logic                  sof_early;
    logic                  line_end;
    logic                  frame_end;
    logic                  eol_early;
    logic                  eol_late;
    logic                  frame_err;
    logic                  frame_err_next;
    logic [DATA_WIDTH-1:0] xor_acc;
    logic [DATA_WIDTH-1:0] xor_next;

    always_comb begin
        beat      = s_axis_video_tvalid && s_axis_video_tready;
        in_active = (state == ACTIVE);
        step      = beat && (in_active || s_axis_video_tuser);
        sof_early = beat && in_active && s_axis_video_tuser;
        xor_next  = s_axis_video_tuser ? s_axis_video_tdata : (xor_acc ^ s_axis_video_tdata);
        // A restarted frame inherits the error of the sof that aborted its predecessor.
        frame_err_next = (s_axis_video_tuser ? 1'b0 : frame_err) | sof_early | eol_early | eol_late;
    end

    stream_frame_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .sof       (s_axis_video_tuser),
        .tlast     (s_axis_video_tlast),
        .line_end  (line_end),
        .frame_end (frame_end),
        .eol_early (eol_early),
        .eol_late  (eol_late)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= SEEK_SOF;
            s_axis_video_tready <= 1'b0;
            xor_acc             <= '0;
            frame_err           <= 1'b0;
            frame_done          <= 1'b0;
            frame_ok            <= 1'b0;
            frame_cnt           <= '0;
            frame_xor           <= '0;
        end else begin
            s_axis_video_tready <= ready_en;
            frame_done          <= 1'b0;
            if (step) begin
                xor_acc   <= xor_next;
                frame_err <= frame_err_next;
                state     <= frame_end ? SEEK_SOF : ACTIVE;
            end
            if (frame_end) begin
                frame_done <= 1'b1;
                frame_ok   <= !frame_err_next;
                frame_xor  <= xor_next;
                frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Sticky flags: a new error event takes priority over a concurrent clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sof_early <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
        end else begin
            if (sof_early)    err_sof_early <= 1'b1;
            else if (err_clr) err_sof_early <= 1'b0;
            if (eol_early)    err_eol_early <= 1'b1;
            else if (err_clr) err_eol_early <= 1'b0;
            if (eol_late)     err_eol_late  <= 1'b1;
            else if (err_clr) err_eol_late  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_video_sink.sv
// Scoreboard bench for stream_video_sink: frames are queued as they are sent and a
// monitor pops and compares on every frame_done.
module tb_stream_video_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        ready_en;
    logic        err_clr = 1'b0;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic [23:0] frame_xor;
    logic        err_sof_early;
    logic        err_eol_early;
    logic        err_eol_late;

    typedef struct {
        logic        ok;
        logic [23:0] xr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        got;
    int          checks = 0;
    int          errors = 0;
    bit          rand_mode = 1'b0;
    logic        ready_level = 1'b0;
    logic [15:0] exp_cnt = '0;
    bit          have_prev = 1'b0;
    logic        prev_rst;
    logic        prev_ready;

    always #5 clk = ~clk;

    stream_video_sink dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_video_tdata  (tdata),
        .s_axis_video_tvalid (tvalid),
        .s_axis_video_tready (tready),
        .s_axis_video_tuser  (tuser),
        .s_axis_video_tlast  (tlast),
        .ready_en            (ready_en),
        .err_clr             (err_clr),
        .frame_done          (frame_done),
        .frame_ok            (frame_ok),
        .frame_cnt           (frame_cnt),
        .frame_xor           (frame_xor),
        .err_sof_early       (err_sof_early),
        .err_eol_early       (err_eol_early),
        .err_eol_late        (err_eol_late)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        ready_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready_en = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // tready must equal ready_en as it stood at the previous rising edge (0 under reset).
    always @(negedge clk) begin
        if (have_prev)
            chk("tready_lag", {31'b0, tready}, {31'b0, prev_rst ? prev_ready : 1'b0});
        prev_rst   = rst;
        prev_ready = ready_en;
        have_prev  = 1'b1;
        if (frame_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done actual=1 required=0 cnt=%0d", frame_cnt);
            end else begin
                got = q.pop_front();
                chk("frame_ok",  {31'b0, frame_ok}, {31'b0, got.ok});
                chk("frame_xor", {8'b0, frame_xor}, {8'b0, got.xr});
                chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, got.cnt});
            end
        end
    end

    function automatic logic [23:0] beat_data(input int seed, input int idx);
        logic [31:0] v;
        if (seed == 0) v = idx;
        else           v = seed * 32'h009E3779 + idx * 32'h0001F3A7;
        return v[23:0];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input logic c);
        bit taken = 1'b0;
        int n = 0;
        if (rand_mode) repeat ($urandom_range(0, 2)) cycle();
        tdata = d; tuser = u; tlast = l; err_clr = c; tvalid = 1'b1;
        while (!taken && n < 100) begin
            @(negedge clk);
            taken = (tready === 1'b1);
            cycle();
            n++;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL beat_accept actual=stalled required=accepted data=%0h", d);
        end
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; err_clr = 1'b0;
    endtask

    // mode 0: clean, 1: tlast at (15,2), 2: no tlast at (19,4)
    task automatic run_frame(input int seed, input int mode, input bit bad_start, input bit clr_on_err);
        logic [23:0] acc = '0;
        logic [23:0] d;
        int idx = 0;
        int len;
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        for (int y = 0; y < 10; y++) begin
            len = (mode == 1 && y == 2) ? 16 : 20;
            for (int x = 0; x < len; x++) begin
                d = beat_data(seed, idx);
                acc = acc ^ d;
                idx++;
                if (y == 9 && x == len - 1) begin
                    e.ok  = (mode == 0) && !bad_start;
                    e.xr  = acc;
                    e.cnt = exp_cnt;
                    q.push_back(e);
                end
                send_beat(d, (x == 0 && y == 0), (x == len - 1) && !(mode == 2 && y == 4),
                          clr_on_err && mode == 1 && y == 2 && x == 15);
            end
        end
    endtask

    task automatic send_partial(input int seed, input int lines, input int px);
        int idx = 0;
        for (int y = 0; y <= lines; y++)
            for (int x = 0; x < ((y == lines) ? px : 20); x++) begin
                send_beat(beat_data(seed, idx), (x == 0 && y == 0), x == 19, 1'b0);
                idx++;
            end
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("frame_done_seen", q.size(), 0);
        repeat (2) cycle();
    endtask

    task automatic check_flags(input logic s, input logic ee, input logic el, input logic [15:0] cnt);
        @(negedge clk);
        chk("err_sof_early", {31'b0, err_sof_early}, {31'b0, s});
        chk("err_eol_early", {31'b0, err_eol_early}, {31'b0, ee});
        chk("err_eol_late",  {31'b0, err_eol_late},  {31'b0, el});
        chk("frame_cnt_now", {16'b0, frame_cnt}, {16'b0, cnt});
        cycle();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", {31'b0, tready}, 0);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("rst_frame_ok", {31'b0, frame_ok}, 0);
        chk("rst_frame_xor", {8'b0, frame_xor}, 0);
        check_flags(1'b0, 1'b0, 1'b0, 16'd0);

        rst = 1'b1;
        ready_level = 1'b1;
        repeat (3) cycle();
        send_beat(24'hABCDEF, 1'b0, 1'b0, 1'b0);
        send_beat(24'h123456, 1'b0, 1'b1, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        wait_done();
        check_flags(1'b0, 1'b0, 1'b0, 16'd1);

        rand_mode = 1'b1;
        for (int i = 0; i < 3; i++) run_frame(i + 1, 0, 1'b0, 1'b0);
        wait_done();
        rand_mode = 1'b0;
        repeat (3) cycle();
        check_flags(1'b0, 1'b0, 1'b0, 16'd4);

        run_frame(5, 1, 1'b0, 1'b0);
        wait_done();
        check_flags(1'b0, 1'b1, 1'b0, 16'd5);
        pulse_clr();
        check_flags(1'b0, 1'b0, 1'b0, 16'd5);

        run_frame(6, 2, 1'b0, 1'b0);
        wait_done();
        check_flags(1'b0, 1'b0, 1'b1, 16'd6);
        pulse_clr();

        send_partial(7, 3, 5);
        run_frame(8, 0, 1'b1, 1'b0);
        wait_done();
        check_flags(1'b1, 1'b0, 1'b0, 16'd7);
        pulse_clr();

        send_partial(9, 5, 10);
        rst = 1'b0;
        repeat (2) cycle();
        @(negedge clk);
        chk("midrst_frame_done", {31'b0, frame_done}, 0);
        check_flags(1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        exp_cnt = '0;
        repeat (2) cycle();
        run_frame(10, 0, 1'b0, 1'b0);
        wait_done();
        check_flags(1'b0, 1'b0, 1'b0, 16'd1);
        run_frame(11, 1, 1'b0, 1'b1);
        wait_done();
        check_flags(1'b0, 1'b1, 1'b0, 16'd2);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
